arb_requester: RTL and testbench

Four-channel requester that drives the `req[3:0]`/`gnt[3:0]` side of the 4-way arbiter. It accepts length-tagged jobs per channel and holds `req[i]` until exactly that many grant beats are consumed. It never over-requests despite the arbiter's one-cycle registered grant. It also checks grant legality and flags starvation, so it serves both as the system-level client and as the bench driver and checker for arbiter regressions.

---
 rtl/arb_pkg.sv | 33 +++
 rtl/arb_req_channel.sv | 92 +++++++++
 rtl/arb_requester.sv | 74 +++++++
 tb/tb_arb_requester.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way arbiter and its requester: channel count,
// channel index type, arbiter policy encodings and a small grant-check helper.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] ch_t;

  typedef enum logic [2:0] {
    P0   = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    RR   = 3'd4,
    RAND = 3'd5
  } arb_type_e;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

  // True when more than one grant line is asserted in the same cycle.
  function automatic logic multi_hot(input logic [NUM_REQ-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + 3'(v[i]);
    end
    return (n > 3'd1);
  endfunction

endpackage

// File: rtl/arb_req_channel.sv
// One requester channel: remaining-beat count, request generation, beat and
// completion pulses, and the starvation wait counter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CH_IDLE   | rem == 0; may load a new job, never requests
// CH_ACTIVE | rem > 0; requests, consumes one beat per grant
module arb_req_channel
  import arb_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int WAIT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             beat,
  output logic             cmpl,
  output logic             starve
);

  localparam logic [WAIT_W-1:0] STARVE_CNT = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  ch_state_e         state;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              beat_q, beat_d;
  logic              cmpl_q, cmpl_d;
  logic              starve_q, starve_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      wait_cnt_q <= '0;
      beat_q     <= 1'b0;
      cmpl_q     <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
      cmpl_q     <= cmpl_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state      = (rem_q == '0) ? CH_IDLE : CH_ACTIVE;
    req        = 1'b0;
    rem_d      = rem_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = 1'b0;
    cmpl_d     = 1'b0;
    starve_d   = starve_q;

    case (state)
      CH_IDLE: begin
        if (load) rem_d = load_len;
      end
      CH_ACTIVE: begin
        // Drop the request when the last grant is already on the wire, so the
        // one-cycle grant latency never yields an extra beat.
        req = (rem_q > LEN_ONE) | ~gnt;
        if (gnt) begin
          rem_d  = rem_q - LEN_ONE;
          beat_d = 1'b1;
          cmpl_d = (rem_q == LEN_ONE);
        end
      end
      default: ;
    endcase

    if (req & ~gnt) begin
      if (wait_cnt_q == STARVE_CNT) starve_d = 1'b1;
      if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  assign busy   = (state == CH_ACTIVE);
  assign beat   = beat_q;
  assign cmpl   = cmpl_q;
  assign starve = starve_q;

endmodule

// File: rtl/arb_requester.sv
// Four-channel length-tagged requester for the 4-way arbiter: job demux,
// per-channel request engines, and sticky grant-legality checks.
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int WAIT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  input  logic [1:0]           job_ch,
  input  logic [LEN_W-1:0]     job_len,
  output logic                 job_ready,
  output logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   beat,
  output logic [NUM_REQ-1:0]   cmpl,
  output logic [NUM_REQ-1:0]   busy,
  output logic [NUM_REQ-1:0]   starve,
  output logic                 err_spurious,
  output logic                 err_onehot
);

  ch_t                job_sel;
  logic [NUM_REQ-1:0] load;
  logic               err_spurious_q, err_spurious_d;
  logic               err_onehot_q, err_onehot_d;

  assign job_sel = job_ch;

  always_comb begin
    job_ready = ~busy[job_sel];
    load      = '0;
    if (job_valid & job_ready) load[job_sel] = 1'b1;
    // A grant to an idle channel is flagged; the channel itself ignores it.
    err_spurious_d = err_spurious_q | (|(gnt & ~busy));
    err_onehot_d   = err_onehot_q | multi_hot(gnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_spurious_q <= 1'b0;
      err_onehot_q   <= 1'b0;
    end else begin
      err_spurious_q <= err_spurious_d;
      err_onehot_q   <= err_onehot_d;
    end
  end

  assign err_spurious = err_spurious_q;
  assign err_onehot   = err_onehot_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
    arb_req_channel #(
      .LEN_W        (LEN_W),
      .STARVE_LIMIT (STARVE_LIMIT),
      .WAIT_W       (WAIT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .load_len (job_len),
      .gnt      (gnt[i]),
      .req      (req[i]),
      .busy     (busy[i]),
      .beat     (beat[i]),
      .cmpl     (cmpl[i]),
      .starve   (starve[i])
    );
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester against a registered fixed-priority (P0)
// arbiter model, with a grant override for illegal-grant cases.
module tb_arb_requester;

  logic       clk;
  logic       rst_n;
  logic       job_valid;
  logic [1:0] job_ch;
  logic [7:0] job_len;

  logic       job_ready, job_ready4;
  logic [3:0] req, gnt, beat, cmpl, busy, starve;
  logic [3:0] req4, gnt4, beat4, cmpl4, busy4, starve4;
  logic       err_spurious, err_onehot, err_spurious4, err_onehot4;

  logic [3:0] gnt_arb, gnt_arb4, force_gnt;
  logic       force_en;

  int n_chk;
  int n_bad;

  arb_requester #(.LEN_W(8), .STARVE_LIMIT(16), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ch(job_ch), .job_len(job_len),
    .job_ready(job_ready), .req(req), .gnt(gnt), .beat(beat), .cmpl(cmpl), .busy(busy),
    .starve(starve), .err_spurious(err_spurious), .err_onehot(err_onehot)
  );

  arb_requester #(.LEN_W(8), .STARVE_LIMIT(4), .WAIT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ch(job_ch), .job_len(job_len),
    .job_ready(job_ready4), .req(req4), .gnt(gnt4), .beat(beat4), .cmpl(cmpl4), .busy(busy4),
    .starve(starve4), .err_spurious(err_spurious4), .err_onehot(err_onehot4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] prio0(input logic [3:0] r);
    return r & (~r + 4'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_arb  <= 4'd0;
      gnt_arb4 <= 4'd0;
    end else begin
      gnt_arb  <= prio0(req);
      gnt_arb4 <= prio0(req4);
    end
  end

  assign gnt  = force_en ? force_gnt : gnt_arb;
  assign gnt4 = force_en ? force_gnt : gnt_arb4;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] ch, input logic [7:0] len);
    job_valid = 1'b1;
    job_ch    = ch;
    job_len   = len;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] req_tab, gnt_tab, beat_tab, cmpl_tab;
    logic [3:0] g2_exp [7];
    logic [3:0] c2_exp [7];
    logic       found;
    logic       seen;

    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_ch = 2'd0;
    job_len = 8'd0;
    force_en = 1'b0;
    force_gnt = 4'd0;

    // reset state
    #12;
    check_val("rst_req", 32'(req), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_beat_cmpl", 32'({beat, cmpl}), 32'h0);
    check_val("rst_starve", 32'(starve), 32'h0);
    check_val("rst_err", 32'({err_spurious, err_onehot}), 32'h0);
    check_val("rst_job_ready", 32'(job_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single job ch0 len 3, back-to-back grants
    req_tab  = 7'b0001110;
    gnt_tab  = 7'b0011100;
    beat_tab = 7'b0111000;
    cmpl_tab = 7'b0100000;
    offer(2'd0, 8'd3);
    check_val("t1_ready", 32'(job_ready), 32'h1);
    tick();
    job_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check_val($sformatf("t1_req_k%0d", k), 32'(req), 32'({3'b000, req_tab[k]}));
      check_val($sformatf("t1_gnt_k%0d", k), 32'(gnt), 32'({3'b000, gnt_tab[k]}));
      check_val($sformatf("t1_beat_k%0d", k), 32'(beat), 32'({3'b000, beat_tab[k]}));
      check_val($sformatf("t1_cmpl_k%0d", k), 32'(cmpl), 32'({3'b000, cmpl_tab[k]}));
      tick();
    end

    // ch0 len 2 then ch3 len 1; ch3 granted only after ch0 finishes
    g2_exp = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0};
    c2_exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8, 4'h0};
    offer(2'd0, 8'd2);
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) offer(2'd3, 8'd1);
      if (k == 2) job_valid = 1'b0;
      check_val($sformatf("t2_gnt_k%0d", k), 32'(gnt), 32'(g2_exp[k]));
      check_val($sformatf("t2_cmpl_k%0d", k), 32'(cmpl), 32'(c2_exp[k]));
      tick();
    end
    check_val("t2_starve3", 32'(starve[3]), 32'h0);

    // starvation with STARVE_LIMIT=4: ch0 len 20 hogs, ch1 len 1 waits
    offer(2'd0, 8'd20);
    tick();
    offer(2'd1, 8'd1);
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    tick();
    check_val("t3_starve_before", 32'(starve4[1]), 32'h0);
    tick();
    check_val("t3_starve_set", 32'(starve4[1]), 32'h1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (cmpl4[1]) found = 1'b1;
      else tick();
    end
    check_val("t3_ch1_cmpl_seen", 32'(found), 32'h1);
    check_val("t3_starve_sticky", 32'(starve4[1]), 32'h1);
    check_val("t3_all_idle", 32'(busy4), 32'h0);
    tick();

    // spurious grant to idle ch2
    force_en = 1'b1;
    force_gnt = 4'b0100;
    check_val("t4_spur_before", 32'(err_spurious), 32'h0);
    tick();
    force_gnt = 4'b0000;
    check_val("t4_spur_set", 32'(err_spurious), 32'h1);
    check_val("t4_spur_beat", 32'(beat), 32'h0);
    check_val("t4_spur_busy", 32'(busy), 32'h0);

    // multi-hot grant with ch0 and ch1 busy (len 3 each)
    offer(2'd0, 8'd3);
    tick();
    offer(2'd1, 8'd3);
    tick();
    job_valid = 1'b0;
    check_val("t4_busy01", 32'(busy), 32'h3);
    check_val("t4_onehot_before", 32'(err_onehot), 32'h0);
    force_gnt = 4'b0011;
    tick();
    check_val("t4_onehot_set", 32'(err_onehot), 32'h1);
    check_val("t4_onehot_beat", 32'(beat), 32'h3);
    check_val("t4_onehot_req", 32'(req), 32'h3);
    tick();
    check_val("t4_cmpl_early", 32'(cmpl), 32'h0);
    tick();
    force_gnt = 4'b0000;
    check_val("t4_cmpl", 32'(cmpl), 32'h3);
    check_val("t4_idle", 32'(busy), 32'h0);

    // job offered to busy ch1 is ignored
    offer(2'd1, 8'd2);
    tick();
    offer(2'd1, 8'd7);
    check_val("t5_ready_busy", 32'(job_ready), 32'h0);
    tick();
    job_valid = 1'b0;
    check_val("t5_busy1", 32'(busy), 32'h2);
    force_gnt = 4'b0010;
    tick();
    tick();
    force_gnt = 4'b0000;
    check_val("t5_cmpl1", 32'(cmpl), 32'h2);
    check_val("t5_idle1", 32'(busy[1]), 32'h0);
    force_en = 1'b0;

    // zero-length job has no effect
    offer(2'd2, 8'd0);
    tick();
    job_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t5_len0_k%0d", k), 32'({req, busy, cmpl}), 32'h0);
      tick();
    end

    // reset mid-job on ch2
    offer(2'd2, 8'd5);
    tick();
    job_valid = 1'b0;
    check_val("t6_busy2", 32'(busy), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_req_busy", 32'({req, busy}), 32'h0);
    check_val("t6_rst_beat_cmpl", 32'({beat, cmpl}), 32'h0);
    check_val("t6_rst_starve", 32'(starve), 32'h0);
    check_val("t6_rst_err", 32'({err_spurious, err_onehot}), 32'h0);
    check_val("t6_rst_ready", 32'(job_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cmpl[2]) seen = 1'b1;
    end
    check_val("t6_no_cmpl2", 32'(seen), 32'h0);
    check_val("t6_ready_after", 32'(job_ready), 32'h1);
    check_val("t6_busy_after", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
